// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_pkg
// Brief    : Shared packed-BCD score type, limits and nibble sanitiser.
// Revision : 1.0
// ============================================================================
package score_pkg;

    typedef logic [7:0] score_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam score_t     SCORE_MAX     = 8'h99;

    // Illegal nibbles (A..F) are treated as the largest legal digit.
    function automatic logic [3:0] sanitizeNibble(input logic [3:0] nibble);
        return (nibble > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : nibble;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_addsub.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_addsub
// Brief    : Single-digit BCD adder/subtractor with carry/borrow in and out.
// Revision : 1.0
// ============================================================================
module bcd_digit_addsub (
    input  logic [3:0] i_digit,
    input  logic [3:0] i_operand,
    input  logic       i_sub,
    input  logic       i_carry,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    logic [4:0] w_sum;
    logic [4:0] w_diff;

    assign w_sum  = {1'b0, i_digit} + {1'b0, i_operand} + {4'd0, i_carry};
    assign w_diff = {1'b0, i_digit} - {1'b0, i_operand} - {4'd0, i_carry};

    // Modulo-16 correction by +/-10 folds the raw binary result back into 0..9.
    always_comb begin
        o_digit = 4'd0;
        o_carry = 1'b0;
        if (i_sub) begin
            if (w_diff[4]) begin
                o_digit = w_diff[3:0] + 4'd10;
                o_carry = 1'b1;
            end else begin
                o_digit = w_diff[3:0];
            end
        end else begin
            if (w_sum > 5'd9) begin
                o_digit = w_sum[3:0] - 4'd10;
                o_carry = 1'b1;
            end else begin
                o_digit = w_sum[3:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/update_score.sv
`default_nettype none
// ============================================================================
// Module   : update_score
// Brief    : Registered packed-BCD score update: hit adds STEP (saturating),
//            miss holds, or decrements when MISS_PENALTY_EN is defined.
// Revision : 1.0
// ============================================================================
module update_score
    import score_pkg::*;
#(
    parameter int     STEP      = 1,
    parameter score_t SAT_VALUE = SCORE_MAX
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   res,
    input  score_t currentScore,
    output score_t nextScore,
    output logic   saturated,
    output logic   bcd_err
);

`ifdef MISS_PENALTY_EN
    localparam logic c_missPenalty = 1'b1;
`else
    localparam logic c_missPenalty = 1'b0;
`endif

    logic [3:0] w_units;
    logic [3:0] w_tens;
    logic       w_bcdErr;
    logic       w_sub;
    logic [3:0] w_unitsOperand;
    logic [3:0] w_unitsOut;
    logic       w_unitsCarry;
    logic [3:0] w_tensOut;
    logic       w_tensCarry;
    score_t     w_result;
    score_t     w_next;
    logic       w_sat;

    score_t     r_nextScore;
    logic       r_saturated;
    logic       r_bcdErr;

    assign w_units  = sanitizeNibble(currentScore[3:0]);
    assign w_tens   = sanitizeNibble(currentScore[7:4]);
    assign w_bcdErr = (currentScore[3:0] > BCD_MAX_DIGIT) || (currentScore[7:4] > BCD_MAX_DIGIT);

    assign w_sub          = ~res & c_missPenalty;
    assign w_unitsOperand = res ? 4'(STEP) : {3'd0, c_missPenalty};

    bcd_digit_addsub u_units (
        .i_digit   (w_units),
        .i_operand (w_unitsOperand),
        .i_sub     (w_sub),
        .i_carry   (1'b0),
        .o_digit   (w_unitsOut),
        .o_carry   (w_unitsCarry)
    );

    bcd_digit_addsub u_tens (
        .i_digit   (w_tens),
        .i_operand (4'd0),
        .i_sub     (w_sub),
        .i_carry   (w_unitsCarry),
        .o_digit   (w_tensOut),
        .o_carry   (w_tensCarry)
    );

    assign w_result = {w_tensOut, w_unitsOut};

    // A tens carry means overflow past 99 on a hit, or a borrow below 00 on a miss.
    always_comb begin
        w_next = w_result;
        w_sat  = 1'b0;
        if (res) begin
            if (w_tensCarry || (w_result > SAT_VALUE)) begin
                w_next = SAT_VALUE;
                w_sat  = 1'b1;
            end
        end else if (w_tensCarry) begin
            w_next = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nextScore <= 8'h00;
            r_saturated <= 1'b0;
            r_bcdErr    <= 1'b0;
        end else begin
            r_nextScore <= w_next;
            r_saturated <= w_sat;
            r_bcdErr    <= w_bcdErr;
        end
    end

    assign nextScore = r_nextScore;
    assign saturated = r_saturated;
    assign bcd_err   = r_bcdErr;

endmodule
`default_nettype wire

// File: tb/tb_update_score.sv
`default_nettype none
// ============================================================================
// Module   : tb_update_score
// Brief    : Vector table plus scoreboard and decimal reference model for
//            update_score (honours MISS_PENALTY_EN).
// Revision : 1.0
// ============================================================================
module tb_update_score;

    typedef struct {
        logic       rst;
        logic       res;
        logic [7:0] cur;
        logic [7:0] expNext;
        logic       expSat;
        logic       expErr;
    } vec_t;

    typedef struct {
        logic [7:0] expNext;
        logic       expSat;
        logic       expErr;
    } exp_t;

`ifdef MISS_PENALTY_EN
    localparam bit c_penalty = 1'b1;
`else
    localparam bit c_penalty = 1'b0;
`endif
    localparam int c_step = 1;

    logic       clk;
    logic       rst;
    logic       res;
    logic [7:0] currentScore;
    logic [7:0] nextScore;
    logic       saturated;
    logic       bcd_err;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];
    exp_t sb[$];

    update_score dut (
        .clk          (clk),
        .rst          (rst),
        .res          (res),
        .currentScore (currentScore),
        .nextScore    (nextScore),
        .saturated    (saturated),
        .bcd_err      (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal-domain reference, independent of the digit-wise datapath.
    function automatic exp_t model(input logic r, input logic h, input logic [7:0] c);
        exp_t e;
        int   t;
        int   u;
        int   v;
        e.expSat = 1'b0;
        e.expErr = 1'b0;
        if (r) begin
            e.expNext = 8'h00;
            return e;
        end
        t = (c[7:4] > 4'd9) ? 9 : int'(c[7:4]);
        u = (c[3:0] > 4'd9) ? 9 : int'(c[3:0]);
        e.expErr = (c[7:4] > 4'd9) || (c[3:0] > 4'd9);
        v = 10 * t + u;
        if (h) begin
            v = v + c_step;
            if (v > 99) begin
                v = 99;
                e.expSat = 1'b1;
            end
        end else if (c_penalty) begin
            v = (v > 0) ? v - 1 : 0;
        end
        e.expNext = {4'(v / 10), 4'(v % 10)};
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyAndCheck(input string tag, input logic r, input logic h,
                                 input logic [7:0] c, input exp_t e);
        exp_t got;
        @(negedge clk);
        rst          = r;
        res          = h;
        currentScore = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            check({tag, ".nextScore"}, nextScore, got.expNext);
            check({tag, ".saturated"}, {7'd0, saturated}, {7'd0, got.expSat});
            check({tag, ".bcd_err"},   {7'd0, bcd_err},   {7'd0, got.expErr});
        end
    endtask

    initial begin
        exp_t e;
        logic [7:0] c;
        logic       h;

        rst = 1'b1;
        res = 1'b0;
        currentScore = 8'h00;

        vecs.push_back('{1'b1, 1'b1, 8'h81, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h81, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h81, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h81, 8'h82, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h40, 8'h41, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h40, c_penalty ? 8'h39 : 8'h40, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h09, 8'h10, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h98, 8'h99, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h99, 8'h99, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hFA, 8'h99, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h3C, c_penalty ? 8'h38 : 8'h39, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h10, c_penalty ? 8'h09 : 8'h10, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hA5, 8'h96, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            e.expNext = vecs[i].expNext;
            e.expSat  = vecs[i].expSat;
            e.expErr  = vecs[i].expErr;
            applyAndCheck($sformatf("vec%0d", i), vecs[i].rst, vecs[i].res, vecs[i].cur, e);
        end

        // Reset in the same cycle as a hit, then release: the following hit must land.
        e = '{8'h00, 1'b0, 1'b0};
        applyAndCheck("rstHit", 1'b1, 1'b1, 8'h55, e);
        e = '{8'h56, 1'b0, 1'b0};
        applyAndCheck("relHit", 1'b0, 1'b1, 8'h55, e);

        // Saturation flag must drop on the cycle after a clamped hit.
        e = '{8'h99, 1'b1, 1'b0};
        applyAndCheck("satSet", 1'b0, 1'b1, 8'h99, e);
        e = '{8'h13, 1'b0, 1'b0};
        applyAndCheck("satClr", 1'b0, 1'b1, 8'h12, e);

        for (int k = 0; k < 60; k++) begin
            c = 8'($urandom_range(0, 255));
            h = 1'($urandom_range(0, 1));
            e = model(1'b0, h, c);
            applyAndCheck($sformatf("rnd%0d_%h_%0d", k, c, h), 1'b0, h, c, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/update_score.md
Name: update_score

Overview:
- Score-update stage for the rhythm game: takes the current two-digit packed-BCD score and a per-note hit result, and produces the registered next score.
- Sits between the note-judging logic (drives `res`) and the score register / 7-segment display path (consumes `nextScore`).
- Hit adds STEP to the score in BCD, saturating at 99; miss holds the score (see optional feature).

Parameters:
- STEP, 1, BCD increment applied on a hit; legal range 1..9.
- SAT_VALUE, 8'h99, packed-BCD ceiling; the score never exceeds this value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- res  input  1  hit result for this cycle: 1 = hit, 0 = miss.
- currentScore  input  8  current score, packed BCD; [7:4] = tens digit, [3:0] = units digit.
- nextScore  output  8  registered updated score, packed BCD.
- saturated  output  1  registered; 1 when a hit was clamped at SAT_VALUE this cycle.
- bcd_err  output  1  registered; 1 when currentScore held an illegal nibble (>9) this cycle.

Behaviour:
- Reset: while rst=1 at a clock edge, nextScore<=8'h00, saturated<=0, bcd_err<=0. rst has priority over all other inputs.
- Latency: one cycle. Output registers sample the inputs every clock with no enable; the result reflects the inputs present at the preceding edge.
- Sanitise: any currentScore nibble >9 is clamped to 9 before arithmetic, and bcd_err<=1 for that cycle.
- Hit (res=1):
  - units_sum = units + STEP. If >9, subtract 10 and carry 1 into tens.
  - tens_sum = tens + carry. If tens_sum >9, or the result exceeds SAT_VALUE, nextScore<=SAT_VALUE and saturated<=1.
  - Otherwise nextScore<=result and saturated<=0.
- Miss (res=0): nextScore<=sanitised currentScore; saturated<=0.
- Boundaries:
  - 8'h99 + hit gives 8'h99 with saturated=1.
  - 8'h09 + hit (STEP=1) gives 8'h10.
  - 8'h00 + miss gives 8'h00.
  - Illegal 8'hFA + hit gives 8'h99 with saturated=1 and bcd_err=1.
- Output is pure packed BCD at all times: no nibble is ever >9.

Optional Feature:
- Macro: MISS_PENALTY_EN.
- Defined: on a miss (res=0), the score decrements by 1 in BCD with borrow, floored at 8'h00.
  - 8'h40 gives 8'h39.
  - 8'h00 gives 8'h00; saturated stays 0.
- Not defined: a miss holds the sanitised score, as in Behaviour.

Decomposition:
- Shared package (score_pkg) holds:
  - typedef of the packed-BCD score (8 bits, two digits);
  - constants BCD_MAX_DIGIT=4'd9 and SCORE_MAX=8'h99;
  - function for nibble sanitise.
- One natural sub-module: bcd_digit_addsub, a single-digit BCD add/subtract with carry/borrow in and out. Instantiate it twice (units, tens) in update_score.

Test Plan:
- rst=1 for 3 cycles with currentScore=8'h81, res=1 -> nextScore=8'h00, saturated=0, bcd_err=0.
- rst=0, res=1, currentScore=8'h81 -> next cycle nextScore=8'h82; then currentScore=8'h40 -> 8'h41.
- res=0, currentScore=8'h40 -> 8'h40 without MISS_PENALTY_EN; 8'h39 with it.
- res=1, currentScore=8'h09 -> 8'h10; currentScore=8'h99 -> 8'h99 with saturated=1.
- res=1, currentScore=8'hFA -> 8'h99, saturated=1, bcd_err=1. res=0, currentScore=8'h3C -> 8'h39, bcd_err=1 (without MISS_PENALTY_EN).
- Assert rst=1 in the same cycle as res=1, currentScore=8'h55 -> nextScore=8'h00. Then release rst -> 8'h56 one cycle later.
